// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: forward-select codes, result-source codes,
// divide controller state type and the register-match helpers used by the hazard unit.
package riscv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DIV_CNT_W  = 6;

    localparam logic [REG_ADDR_W-1:0] REG_X0       = '0;
    localparam logic [DIV_CNT_W-1:0]  DIV_CNT_ZERO = '0;
    localparam logic [DIV_CNT_W-1:0]  DIV_CNT_ONE  = DIV_CNT_W'(1);

    localparam logic [1:0] FWD_RF         = 2'b00;
    localparam logic [1:0] FWD_WB         = 2'b01;
    localparam logic [1:0] FWD_MEM        = 2'b10;
    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } hzrd_div_state_e;

    // x0 is hard-wired to zero, so a stage writing it never produces a usable value.
    function automatic logic src_hit(input logic                  wr,
                                     input logic [REG_ADDR_W-1:0] rd,
                                     input logic [REG_ADDR_W-1:0] rs);
        return wr && (rd != REG_X0) && (rd == rs);
    endfunction

    function automatic logic [1:0] fwd_select(input logic [REG_ADDR_W-1:0] rs,
                                              input logic [REG_ADDR_W-1:0] rd_m,
                                              input logic                  wr_m,
                                              input logic [REG_ADDR_W-1:0] rd_w,
                                              input logic                  wr_w);
        logic [1:0] sel;
        sel = FWD_RF;
        if (src_hit(wr_m, rd_m, rs)) begin
            sel = FWD_MEM;
        end else if (src_hit(wr_w, rd_w, rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/riscv_hzrd_divctl.sv
// Divide/remainder sequencer: IDLE -> BUSY for DIV_LATENCY cycles -> one DONE cycle.
// busy and done are registered alongside the state so they are glitch-free.
module riscv_hzrd_divctl
    import riscv_pkg::*;
#(
    parameter int DIV_LATENCY = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output hzrd_div_state_e state,
    output logic            busy,
    output logic            done
);

    localparam logic [DIV_CNT_W-1:0] CNT_LOAD = DIV_CNT_W'(DIV_LATENCY) - DIV_CNT_ONE;

    logic [DIV_CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
            count <= DIV_CNT_ZERO;
            busy  <= '0;
            done  <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        state <= DIV_BUSY;
                        count <= CNT_LOAD;
                        busy  <= '1;
                    end
                end
                // The counter runs CNT_LOAD..0 inclusive, giving exactly DIV_LATENCY BUSY cycles.
                DIV_BUSY: begin
                    if (count == DIV_CNT_ZERO) begin
                        state <= DIV_DONE;
                        busy  <= '0;
                        done  <= '1;
                    end else begin
                        count <= count - DIV_CNT_ONE;
                    end
                end
                DIV_DONE: begin
                    state <= DIV_IDLE;
                    done  <= '0;
                end
                default: begin
                    state <= DIV_IDLE;
                    count <= DIV_CNT_ZERO;
                    busy  <= '0;
                    done  <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/riscv_hazard_unit.sv
// Pipeline hazard unit: load-use/RAW stalls, branch flushes, operand forwarding and divide stalls.
// Forwarding is built only when RISCV_HZRD_FWD_EN is defined; otherwise E/M RAW hazards stall.
module riscv_hazard_unit
    import riscv_pkg::*;
#(
    parameter int DIV_LATENCY = 32
) (
    input  logic                  i_riscv_hzrd_clk,
    input  logic                  i_riscv_hzrd_rst,
    input  logic [REG_ADDR_W-1:0] i_riscv_hzrd_rs1addr_d,
    input  logic [REG_ADDR_W-1:0] i_riscv_hzrd_rs2addr_d,
    input  logic [REG_ADDR_W-1:0] i_riscv_hzrd_rs1addr_e,
    input  logic [REG_ADDR_W-1:0] i_riscv_hzrd_rs2addr_e,
    input  logic [REG_ADDR_W-1:0] i_riscv_hzrd_rdaddr_e,
    input  logic [1:0]            i_riscv_hzrd_resultsrc_e,
    input  logic                  i_riscv_hzrd_regwrite_e,
    input  logic                  i_riscv_hzrd_pcsrc_e,
    input  logic                  i_riscv_hzrd_muldiv_e,
    input  logic [REG_ADDR_W-1:0] i_riscv_hzrd_rdaddr_m,
    input  logic                  i_riscv_hzrd_regwrite_m,
    input  logic [REG_ADDR_W-1:0] i_riscv_hzrd_rdaddr_w,
    input  logic                  i_riscv_hzrd_regwrite_w,
    output logic                  o_riscv_hzrd_stall_pc,
    output logic                  o_riscv_hzrd_stall_fd,
    output logic                  o_riscv_hzrd_stall_de,
    output logic                  o_riscv_hzrd_flush_fd,
    output logic                  o_riscv_hzrd_flush_de,
    output logic [1:0]            o_riscv_hzrd_fwda_e,
    output logic [1:0]            o_riscv_hzrd_fwdb_e,
    output logic                  o_riscv_hzrd_div_busy,
    output logic                  o_riscv_hzrd_div_done
);

    hzrd_div_state_e div_state;
    logic            div_start;
    logic            div_busy;
    logic            div_done;
    logic            div_launch;
    logic            div_stall;
    logic            load_use;
    logic            raw_stall;
    logic            hazard;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;

    // A taken branch in E kills the divide before it launches.
    assign div_start = i_riscv_hzrd_muldiv_e && !i_riscv_hzrd_pcsrc_e;

    riscv_hzrd_divctl #(
        .DIV_LATENCY(DIV_LATENCY)
    ) u_divctl (
        .clk   (i_riscv_hzrd_clk),
        .rst   (i_riscv_hzrd_rst),
        .start (div_start),
        .state (div_state),
        .busy  (div_busy),
        .done  (div_done)
    );

    assign div_launch = (div_state == DIV_IDLE) && div_start;
    assign div_stall  = div_launch || div_busy;

    assign load_use = (i_riscv_hzrd_resultsrc_e == RESULTSRC_LOAD) &&
                      (src_hit(i_riscv_hzrd_regwrite_e, i_riscv_hzrd_rdaddr_e, i_riscv_hzrd_rs1addr_d) ||
                       src_hit(i_riscv_hzrd_regwrite_e, i_riscv_hzrd_rdaddr_e, i_riscv_hzrd_rs2addr_d));

`ifdef RISCV_HZRD_FWD_EN
    assign raw_stall = load_use;
    assign fwd_a = fwd_select(i_riscv_hzrd_rs1addr_e, i_riscv_hzrd_rdaddr_m, i_riscv_hzrd_regwrite_m,
                              i_riscv_hzrd_rdaddr_w, i_riscv_hzrd_regwrite_w);
    assign fwd_b = fwd_select(i_riscv_hzrd_rs2addr_e, i_riscv_hzrd_rdaddr_m, i_riscv_hzrd_regwrite_m,
                              i_riscv_hzrd_rdaddr_w, i_riscv_hzrd_regwrite_w);
`else
    // Without bypass paths any pending E or M write must drain first; W relies on write-before-read.
    assign raw_stall = load_use ||
                       src_hit(i_riscv_hzrd_regwrite_e, i_riscv_hzrd_rdaddr_e, i_riscv_hzrd_rs1addr_d) ||
                       src_hit(i_riscv_hzrd_regwrite_e, i_riscv_hzrd_rdaddr_e, i_riscv_hzrd_rs2addr_d) ||
                       src_hit(i_riscv_hzrd_regwrite_m, i_riscv_hzrd_rdaddr_m, i_riscv_hzrd_rs1addr_d) ||
                       src_hit(i_riscv_hzrd_regwrite_m, i_riscv_hzrd_rdaddr_m, i_riscv_hzrd_rs2addr_d);
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{i_riscv_hzrd_rs1addr_e, i_riscv_hzrd_rs2addr_e,
                                 i_riscv_hzrd_rdaddr_w, i_riscv_hzrd_regwrite_w};
`endif

    // The divide owns the pipeline while launching/busy; in DONE every stall is released.
    assign hazard = raw_stall && !div_stall && (div_state != DIV_DONE);

    assign o_riscv_hzrd_stall_pc = !i_riscv_hzrd_rst && (div_stall || (hazard && !i_riscv_hzrd_pcsrc_e));
    assign o_riscv_hzrd_stall_fd = !i_riscv_hzrd_rst && (div_stall || (hazard && !i_riscv_hzrd_pcsrc_e));
    assign o_riscv_hzrd_stall_de = !i_riscv_hzrd_rst && div_stall;
    assign o_riscv_hzrd_flush_fd = !i_riscv_hzrd_rst && !div_stall && i_riscv_hzrd_pcsrc_e;
    assign o_riscv_hzrd_flush_de = !i_riscv_hzrd_rst && !div_stall && (i_riscv_hzrd_pcsrc_e || hazard);
    assign o_riscv_hzrd_fwda_e   = i_riscv_hzrd_rst ? FWD_RF : fwd_a;
    assign o_riscv_hzrd_fwdb_e   = i_riscv_hzrd_rst ? FWD_RF : fwd_b;
    assign o_riscv_hzrd_div_busy = !i_riscv_hzrd_rst && div_busy;
    assign o_riscv_hzrd_div_done = !i_riscv_hzrd_rst && div_done;

endmodule

// File: doc/riscv_hazard_unit.md
RISCV_HAZARD_UNIT -- requirements
Module: riscv_hazard_unit

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high, named i_riscv_hzrd_clk and i_riscv_hzrd_rst.
REQ-002 Parameter DIV_LATENCY SHALL default to 32 and SHALL set the number of BUSY cycles for a divide/remainder operation (legal range 2..63).
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- i_riscv_hzrd_clk, in, 1, clock.
- i_riscv_hzrd_rst, in, 1, synchronous active-high reset.
- i_riscv_hzrd_rs1addr_d and i_riscv_hzrd_rs2addr_d, in, 5, decode source registers.
- i_riscv_hzrd_rs1addr_e and i_riscv_hzrd_rs2addr_e, in, 5, execute source registers, taken from the DE register.
- i_riscv_hzrd_rdaddr_e, in, 5, execute destination register.
- i_riscv_hzrd_resultsrc_e, in, 2, execute result source; 2'b01 means load.
- i_riscv_hzrd_regwrite_e, in, 1, execute writes the register file.
- i_riscv_hzrd_pcsrc_e, in, 1, branch taken or jump in execute.
- i_riscv_hzrd_muldiv_e, in, 1, execute holds a div/rem instruction.
- i_riscv_hzrd_rdaddr_m, in, 5, memory-stage destination register.
- i_riscv_hzrd_regwrite_m, in, 1, memory-stage register write.
- i_riscv_hzrd_rdaddr_w, in, 5, writeback-stage destination register.
- i_riscv_hzrd_regwrite_w, in, 1, writeback-stage register write.
- o_riscv_hzrd_stall_pc, out, 1, hold the PC.
- o_riscv_hzrd_stall_fd, out, 1, hold the FD register.
- o_riscv_hzrd_stall_de, out, 1, hold the DE register.
- o_riscv_hzrd_flush_fd, out, 1, clear the FD register.
- o_riscv_hzrd_flush_de, out, 1, clear the DE register; this port drives the DE register's flush/reset input.
- o_riscv_hzrd_fwda_e, out, 2, operand-A forward select.
- o_riscv_hzrd_fwdb_e, out, 2, operand-B forward select.
- o_riscv_hzrd_div_busy, out, 1, divide in progress.
- o_riscv_hzrd_div_done, out, 1, one-cycle pulse when the divide result is valid.

Function
REQ-004 The forward-select encodings SHALL be 2'b00 = register file, 2'b01 = writeback, 2'b10 = memory; a memory-stage match SHALL take priority over a writeback-stage match.
REQ-005 A stage SHALL be a forward or hazard source only when its regwrite is 1 and its rd is non-zero.
REQ-006 A load-use hazard SHALL be detected when resultsrc_e = 2'b01, regwrite_e = 1, rdaddr_e != 0, and rdaddr_e equals rs1addr_d or rs2addr_d; in that cycle, combinationally, stall_pc = 1, stall_fd = 1 and flush_de = 1, which inserts exactly one bubble.
REQ-007 pcsrc_e = 1 SHALL assert flush_fd = 1 and flush_de = 1 in the same cycle; it SHALL override a load-use stall, so stall_pc = 0 and stall_fd = 0 in that cycle.
REQ-008 The divide controller SHALL be a three-state FSM (IDLE, BUSY, DONE) with a 6-bit down-counter:
- IDLE to BUSY: when muldiv_e = 1 and pcsrc_e = 0; the counter loads DIV_LATENCY-1.
- BUSY: the counter decrements each cycle; BUSY to DONE when the counter = 0.
- DONE to IDLE: unconditional, after one cycle.
REQ-009 In BUSY, and in the IDLE cycle that launches BUSY, the block SHALL assert stall_pc = 1, stall_fd = 1 and stall_de = 1, and SHALL hold flush_fd = 0 and flush_de = 0; load-use and pcsrc_e effects SHALL be masked.
REQ-010 div_busy SHALL be 1 only in BUSY.
REQ-011 div_done SHALL be 1 only in DONE; in DONE all stalls SHALL be released so the DE register advances at the end of that cycle.
REQ-012 Back-to-back divides SHALL each take DIV_LATENCY+2 cycles: the launch cycle, DIV_LATENCY BUSY cycles, and one DONE cycle.

Reset
REQ-013 A reset asserted in any state, including mid-BUSY, SHALL return the FSM to IDLE and the counter to 0 on the next clock edge; any divide in progress is abandoned.
REQ-014 While reset is asserted, all outputs SHALL be 0.

Configuration
REQ-015 When macro RISCV_HZRD_FWD_EN is defined, the block SHALL forward per REQ-004 and REQ-005.
REQ-016 When RISCV_HZRD_FWD_EN is undefined:
- fwda_e and fwdb_e SHALL be tied to 2'b00.
- A RAW hazard between rs1addr_d/rs2addr_d and a valid E or M destination SHALL stall as in REQ-006.
- Writeback hazards SHALL be resolved by the register file's write-before-read.

Structure
REQ-017 The shared package riscv_pkg SHALL hold the following; no literals SHALL appear in the RTL:
- the enum hzrd_div_state_e;
- the constants FWD_RF, FWD_WB, FWD_MEM and RESULTSRC_LOAD.
REQ-018 The FSM and counter SHALL be a sub-module named riscv_hzrd_divctl; the hazard and forwarding logic SHALL stay combinational in the top level.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Load x5 in E (resultsrc_e = 01, rdaddr_e = 5) with rs2addr_d = 5 -> for one cycle stall_pc = stall_fd = flush_de = 1; the next cycle all are 0.
- rdaddr_m = 7 and rdaddr_w = 7, both writing, rs1addr_e = 7 -> fwda_e = 10; with regwrite_m = 0 -> fwda_e = 01; with rdaddr_m = rdaddr_w = 0 -> fwda_e = 00.
- pcsrc_e = 1 together with a load-use hazard -> flush_fd = flush_de = 1 and stall_pc = stall_fd = 0.
- muldiv_e = 1 with DIV_LATENCY = 4 -> stalls high for 5 cycles, div_busy high for 4, then one div_done pulse with stalls low.
- Reset asserted at the third BUSY cycle -> next cycle FSM in IDLE and all outputs 0; deassert with muldiv_e = 0 -> no stall.
- RISCV_HZRD_FWD_EN undefined, rdaddr_m = 3 writing, rs1addr_d = 3 -> stall asserted and fwda_e = 00.
